fpadd_ctrl: RTL

Multi-cycle controller that shares one FP adder datapath (mask -> align -> alu -> normal -> pack) between NUM_REQ requesters.
- Arbitrates incoming add requests round-robin and latches the granted operand pair.
- Steps the datapath through its five stages, one stage-enable per cycle.
- Captures the packed Result and returns it to the winner with its requester ID over a valid/ready response channel.
- Sits between the requester fabric and the fpbus-connected stage modules.

---
 rtl/fpadd_ctrl_if.sv | 45 ++++
 rtl/fpadd_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_ctrl_if.sv
// ----------------------------------------------------------------------------
// fpadd_ctrl_if
// Bundle of the requester, datapath and response signals around the shared
// FP adder controller.
//   master : requester fabric / datapath side (drives requests, dp_result,
//            rsp_ready; observes grants, operands, stage enables, responses)
//   slave  : the controller (fpadd_ctrl)
// Parameters:
//   NUM_REQ : number of requesters
//   ID_W    : requester ID width (2**ID_W >= NUM_REQ)
// ----------------------------------------------------------------------------
interface fpadd_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [31:0]           dp_a;
    logic [31:0]           dp_b;
    logic                  mask_en;
    logic                  align_en;
    logic                  alu_en;
    logic                  norm_en;
    logic                  pack_en;
    logic [31:0]           dp_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, dp_result, rsp_ready,
        input  req_ready, dp_a, dp_b, mask_en, align_en, alu_en, norm_en,
               pack_en, rsp_valid, rsp_id, rsp_result, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, dp_result, rsp_ready,
        output req_ready, dp_a, dp_b, mask_en, align_en, alu_en, norm_en,
               pack_en, rsp_valid, rsp_id, rsp_result, busy
    );
endinterface

// File: rtl/fpadd_ctrl.sv
// ----------------------------------------------------------------------------
// fpadd_ctrl
// Shares one five-stage FP adder datapath (mask, align, alu, normal, pack)
// between NUM_REQ requesters. Round-robin arbitration in IDLE latches the
// winning operand pair onto dp_a/dp_b, the FSM then pulses one stage enable
// per cycle, captures dp_result at the end of PACK and returns it with the
// winner's ID over a valid/ready response channel.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fpadd_ctrl_if.slave (requests, datapath bus, response, busy)
//
// Optional feature macro: FPADD_CTRL_ZERO_BYPASS_EN
//   When defined, a granted pair with a zero operand (bits[30:0]==0) skips
//   the datapath and goes straight to RESP with the non-zero operand (or a
//   signed zero when both are zero).
//
// States:
//   state   | meaning
//   IDLE    | arbitrating, req_ready to the round-robin winner
//   MASK    | mask_en high
//   ALIGN   | align_en high
//   ALU     | alu_en high
//   NORM    | norm_en high
//   PACK    | pack_en high, dp_result captured on exit
//   RESP    | rsp_valid high until rsp_ready
// ----------------------------------------------------------------------------
module fpadd_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fpadd_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MASK,
        S_ALIGN,
        S_ALU,
        S_NORM,
        S_PACK,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [31:0]         dp_a_q, dp_a_d;
    logic [31:0]         dp_b_q, dp_b_d;
    logic [31:0]         rsp_result_q, rsp_result_d;

    logic                grant_vld;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     rr_next;
    logic [31:0]         grant_a, grant_b;
    logic [NUM_REQ-1:0]  req_ready_c;
    logic                mask_en_c, align_en_c, alu_en_c, norm_en_c, pack_en_c;
    logic                rsp_valid_c;

    // Requester index base+off, wrapped modulo NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // First valid requester at or after rr_ptr, in wrapped order.
    always_comb begin : arb
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && bus.req_valid[wrap_idx(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    assign rr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_comb begin : operand_mux
        grant_a = '0;
        grant_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_a = bus.req_a[32*i +: 32];
                grant_b = bus.req_b[32*i +: 32];
            end
        end
    end

    // Held low during reset so every output reads zero while rst is high.
    always_comb begin : ready_decode
        req_ready_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_c[i] = !rst && (state_q == S_IDLE) && grant_vld &&
                             (grant_idx == ID_W'(i));
        end
    end

`ifdef FPADD_CTRL_ZERO_BYPASS_EN
    logic        zero_a, zero_b;
    logic [31:0] bypass_res;

    assign zero_a = (grant_a[30:0] == 31'd0);
    assign zero_b = (grant_b[30:0] == 31'd0);

    always_comb begin : bypass_value
        bypass_res = {grant_a[31] & grant_b[31], 31'd0};
        if (!zero_a) begin
            bypass_res = grant_a;
        end else if (!zero_b) begin
            bypass_res = grant_b;
        end
    end
`endif

    always_comb begin : fsm_comb
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_id_d     = rsp_id_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        rsp_result_d = rsp_result_q;
        mask_en_c    = 1'b0;
        align_en_c   = 1'b0;
        alu_en_c     = 1'b0;
        norm_en_c    = 1'b0;
        pack_en_c    = 1'b0;
        rsp_valid_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    dp_a_d   = grant_a;
                    dp_b_d   = grant_b;
                    rsp_id_d = grant_idx;
                    rr_ptr_d = rr_next;
                    state_d  = S_MASK;
`ifdef FPADD_CTRL_ZERO_BYPASS_EN
                    if (zero_a || zero_b) begin
                        rsp_result_d = bypass_res;
                        state_d      = S_RESP;
                    end
`endif
                end
            end
            S_MASK: begin
                mask_en_c = 1'b1;
                state_d   = S_ALIGN;
            end
            S_ALIGN: begin
                align_en_c = 1'b1;
                state_d    = S_ALU;
            end
            S_ALU: begin
                alu_en_c = 1'b1;
                state_d  = S_NORM;
            end
            S_NORM: begin
                norm_en_c = 1'b1;
                state_d   = S_PACK;
            end
            S_PACK: begin
                pack_en_c    = 1'b1;
                rsp_result_d = bus.dp_result;
                state_d      = S_RESP;
            end
            S_RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.dp_a       = dp_a_q;
    assign bus.dp_b       = dp_b_q;
    assign bus.mask_en    = mask_en_c;
    assign bus.align_en   = align_en_c;
    assign bus.alu_en     = alu_en_c;
    assign bus.norm_en    = norm_en_c;
    assign bus.pack_en    = pack_en_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule
